mcycle_iter: RTL and testbench

Parametrised iterative multiply/divide unit. Successor to the fixed 32-bit MCycle block, adding signed/unsigned mode, a divide-by-zero flag and an explicit Busy/Done handshake. Sits beside the ALU in the execute stage. The decoder's Start and MCycleOp outputs drive it, and the control unit stalls the pipeline while Busy=1.

---
 rtl/mcycle_if.sv | 37 +++
 rtl/mcycle_iter.sv | 155 +++++++++++++++
 tb/tb_mcycle_iter.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/mcycle_if.sv
// mcycle_if: request/response bundle between the execute-stage control and
// the iterative multiply/divide unit.
//   Start      request pulse
//   MCycleOp   0 = multiply, 1 = divide
//   Signed     1 = two's-complement operands
//   Operand1   multiplicand / dividend
//   Operand2   multiplier / divisor
//   Result1    product low half / quotient
//   Result2    product high half / remainder
//   Busy       operation in progress
//   Done       one-cycle pulse, results valid
//   DivByZero  last divide had a zero divisor
// The master modport is the requester; the slave modport is the unit.
interface mcycle_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             MCycleOp;
  logic             Signed;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;
  logic             DivByZero;

  modport master (
    output Start, MCycleOp, Signed, Operand1, Operand2,
    input  Result1, Result2, Busy, Done, DivByZero
  );

  modport slave (
    input  Start, MCycleOp, Signed, Operand1, Operand2,
    output Result1, Result2, Busy, Done, DivByZero
  );
endinterface

// File: rtl/mcycle_iter.sv
// mcycle_iter: iterative multiply/divide unit, one bit per cycle.
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset
//   bus    mcycle_if.slave (Start/MCycleOp/Signed/Operand1/Operand2 in,
//          Result1/Result2/Busy/Done/DivByZero out)
// Multiply: radix-2 shift-add over a 2*WIDTH accumulator.
// Divide: restoring shift-subtract, quotient truncated toward zero.
// Operands are reduced to magnitudes at acceptance; signs are reapplied on
// the final edge.
// Optional macro MCYCLE_EARLY_OUT_EN: a multiply finishes as soon as the
// remaining multiplier bits are all zero.
module mcycle_iter #(
  parameter int WIDTH = 32
) (
  input  logic     CLK,
  input  logic     RESET,
  mcycle_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t             state, next_state;
  logic [CW-1:0]      cnt;
  logic               op_div, neg_lo, neg_hi, dbz_pend;
  logic [WIDTH-1:0]   opa;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   res1, res2;
  logic               busy, done, dbz_flag;

  function automatic logic [WIDTH-1:0] neg_w(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic n, input logic [2*WIDTH-1:0] v);
    return n ? -v : v;
  endfunction

  logic               accept, last, finish;
  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, mul_fin;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               early;

  assign accept = bus.Start && (state != COMPUTE);
  assign s1     = bus.Signed && bus.Operand1[WIDTH-1];
  assign s2     = bus.Signed && bus.Operand2[WIDTH-1];
  assign mag1   = s1 ? -bus.Operand1 : bus.Operand1;
  assign mag2   = s2 ? -bus.Operand2 : bus.Operand2;

  // Shift-add step: add multiplicand to the upper half when the current
  // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opa} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: the borrow bit of the trial subtraction decides the
  // quotient bit and whether the shifted remainder is kept.
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opa};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign last = (cnt == CW'(WIDTH - 1));

`ifdef MCYCLE_EARLY_OUT_EN
  logic [WIDTH-1:0] rem_mask;
  // After step cnt the unprocessed multiplier bits occupy the low
  // WIDTH-1-cnt positions; once they are zero the product only needs to be
  // shifted into place.
  assign rem_mask = {WIDTH{1'b1}} >> (int'(cnt) + 1);
  assign early    = !op_div && ((mul_next[WIDTH-1:0] & rem_mask) == '0);
  assign mul_fin  = mul_next >> (WIDTH - 1 - int'(cnt));
`else
  assign early    = 1'b0;
  assign mul_fin  = mul_next;
`endif

  assign finish = dbz_pend || last || early;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.Start) next_state = COMPUTE;
      COMPUTE: if (finish)    next_state = DONE;
      DONE:    next_state = bus.Start ? COMPUTE : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dbz_flag <= 1'b0;
      res1     <= '0;
      res2     <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == COMPUTE);
      done  <= (next_state == DONE);
      if (accept) begin
        cnt      <= '0;
        dbz_flag <= 1'b0;
      end else if (state == COMPUTE) begin
        cnt <= cnt + 1'b1;
        if (finish) begin
          dbz_flag <= dbz_pend;
          if (dbz_pend) begin
            res1 <= '1;
            res2 <= acc[2*WIDTH-1:WIDTH];
          end else if (op_div) begin
            res1 <= neg_w(neg_lo, div_next[WIDTH-1:0]);
            res2 <= neg_w(neg_hi, div_next[2*WIDTH-1:WIDTH]);
          end else begin
            {res2, res1} <= neg_2w(neg_lo, mul_fin);
          end
        end
      end
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_div   <= bus.MCycleOp;
      neg_lo   <= s1 ^ s2;
      neg_hi   <= s1;
      dbz_pend <= bus.MCycleOp && (bus.Operand2 == '0);
      if (!bus.MCycleOp) begin
        opa <= mag1;
        acc <= {{WIDTH{1'b0}}, mag2};
      end else if (bus.Operand2 == '0) begin
        // Raw dividend parked in the upper half for the remainder output.
        opa <= '0;
        acc <= {bus.Operand1, {WIDTH{1'b0}}};
      end else begin
        opa <= mag2;
        acc <= {{WIDTH{1'b0}}, mag1};
      end
    end else if (state == COMPUTE) begin
      acc <= op_div ? div_next : mul_next;
    end
  end

  assign bus.Result1   = res1;
  assign bus.Result2   = res2;
  assign bus.Busy      = busy;
  assign bus.Done      = done;
  assign bus.DivByZero = dbz_flag;
endmodule

// File: tb/tb_mcycle_iter.sv
// tb_mcycle_iter: randomized self-checking bench for mcycle_iter (WIDTH=32).
// Expected results come from integer arithmetic on 64-bit values; expected
// latency comes from the timing rules of the unit.
module tb_mcycle_iter;
  localparam int W = 32;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  mcycle_if #(.WIDTH(W)) mc ();
  mcycle_iter #(.WIDTH(W)) dut (.CLK(CLK), .RESET(RESET), .bus(mc));

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] prev_r1, prev_r2;
  logic         prev_dz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r1, output logic [W-1:0] r2, output bit dz,
                       output int lat);
    longint sa, sb, p, q, r;
    logic [W-1:0] m;
    dz  = 1'b0;
    lat = W + 1;
    sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (op && b == '0) begin
      r1 = '1; r2 = a; dz = 1'b1; lat = 2;
    end else if (!op) begin
      p  = sa * sb;
      r1 = p[31:0];
      r2 = p[63:32];
`ifdef MCYCLE_EARLY_OUT_EN
      m   = (sgn && b[W-1]) ? -b : b;
      lat = 2;
      for (int i = 0; i < W; i++) if (m[i]) lat = i + 2;
`else
      m = b;
`endif
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      r1 = q[31:0];
      r2 = r[31:0];
    end
  endtask

  // Issues one operation at a negedge and follows it to Done. Returns at the
  // negedge of the Done cycle so a following call is a back-to-back request.
  // poke > 0: a new Start with other operands at that cycle (must be ignored).
  // abort > 0: RESET at that cycle instead of completion.
  task automatic run_op(input bit op, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int poke, input int abort);
    logic [W-1:0] e1, e2;
    bit ez, poked, seen;
    int lat;
    model(op, sgn, a, b, e1, e2, ez, lat);
    mc.Start = 1'b1; mc.MCycleOp = op; mc.Signed = sgn; mc.Operand1 = a; mc.Operand2 = b;
    @(posedge CLK); #1;
    mc.Start = 1'b0; mc.Operand1 = $urandom; mc.Operand2 = $urandom;
    poked = 1'b0; seen = 1'b0;
    for (int n = 1; n <= 80 && !seen; n++) begin
      @(negedge CLK);
      if (poked) begin mc.Start = 1'b0; poked = 1'b0; end
      if (abort != 0 && n == abort) begin
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check("abort_busy", mc.Busy, 0);
        check("abort_done", mc.Done, 0);
        check("abort_r1", mc.Result1, 0);
        check("abort_r2", mc.Result2, 0);
        check("abort_dz", mc.DivByZero, 0);
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          check("abort_no_done", mc.Done, 0);
        end
        prev_r1 = '0; prev_r2 = '0; prev_dz = 1'b0;
        return;
      end
      if (mc.Done) begin
        seen = 1'b1;
        check("latency", n, lat);
        check("done_busy", mc.Busy, 0);
        check("r1", mc.Result1, e1);
        check("r2", mc.Result2, e2);
        check("dz", mc.DivByZero, ez);
        prev_r1 = mc.Result1; prev_r2 = mc.Result2; prev_dz = mc.DivByZero;
      end else begin
        check("busy", mc.Busy, 1);
        check("hold_r1", mc.Result1, prev_r1);
        check("hold_r2", mc.Result2, prev_r2);
        if (n == poke) begin
          mc.Start = 1'b1; mc.MCycleOp = ~op; mc.Signed = ~sgn;
          mc.Operand1 = $urandom; mc.Operand2 = $urandom;
          poked = 1'b1;
        end
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge CLK);
      check("idle_done", mc.Done, 0);
      check("idle_busy", mc.Busy, 0);
      check("idle_r1", mc.Result1, prev_r1);
      check("idle_r2", mc.Result2, prev_r2);
      check("idle_dz", mc.DivByZero, prev_dz);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    mc.Start = 1'b0; mc.MCycleOp = 1'b0; mc.Signed = 1'b0;
    mc.Operand1 = '0; mc.Operand2 = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", mc.Busy, 0);
    check("rst_done", mc.Done, 0);
    check("rst_r1", mc.Result1, 0);
    check("rst_r2", mc.Result2, 0);
    check("rst_dz", mc.DivByZero, 0);
    RESET = 1'b0;
    prev_r1 = '0; prev_r2 = '0; prev_dz = 1'b0;
    idle(1);

    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    check("t1_r1", mc.Result1, 32'h0000_0001);
    check("t1_r2", mc.Result2, 32'hFFFF_FFFE);
    idle(1);

    run_op(1'b0, 1'b1, -32'sd3, 32'd5, 0, 0);
    check("t2_r1", mc.Result1, 32'hFFFF_FFF1);
    run_op(1'b0, 1'b0, 32'h8000_0000, 32'd2, 0, 0);
    check("t2b_r2", mc.Result2, 32'd1);

    run_op(1'b1, 1'b1, -32'sd7, 32'd2, 0, 0);
    check("t3_r1", mc.Result1, 32'hFFFF_FFFD);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    check("t3b_r1", mc.Result1, 32'h8000_0000);
    idle(2);

    run_op(1'b1, 1'b0, 32'd100, 32'd0, 0, 0);
    check("t4_r2", mc.Result2, 32'd100);
    run_op(1'b1, 1'b0, 32'd9, 32'd4, 0, 0);
    check("t4b_dz", mc.DivByZero, 0);
    idle(1);

    run_op(1'b0, 1'b0, 32'd1234, 32'd5678, 5, 0);
    idle(1);
    run_op(1'b1, 1'b0, 32'd1000, 32'd7, 0, 10);

    run_op(1'b0, 1'b0, 32'd7, 32'd3, 0, 0);
    check("t6_r1", mc.Result1, 32'd21);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      bit op, sgn;
      logic [W-1:0] a, b;
      op  = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      a   = pick();
      b   = pick();
      run_op(op, sgn, a, b, 0, 0);
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
